cpu_mem_arbiter: RTL and testbench

Shares one single-port unified memory between the CPU instruction-fetch port and the CPU data port. Requests use a level-held req/valid handshake. Grants alternate round-robin when both ports request. A watchdog aborts any memory access that stalls too long. It sits between the core (pc/instr and data_addr/write_data/we/dmemdata) and the memory, and the core stalls until each port's valid pulse arrives.

---
 rtl/cpu_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU fetch
// and data ports, with a watchdog that aborts stalled memory accesses.
module cpu_mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          err,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {GNT_I, GNT_D} port_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_n;
  port_t         last_gnt, last_gnt_n;
  port_t         owner, owner_n;
  logic [7:0]    cnt, cnt_n;
  logic          grant_d;
  logic          m_req_n, m_we_n, busy_n, err_n;
  logic          i_valid_n, d_valid_n;
  logic [AW-1:0] m_addr_n;
  logic [DW-1:0] m_wdata_n, i_rdata_n, d_rdata_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_gnt <= GNT_D;
      owner    <= GNT_I;
      cnt      <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_rdata  <= '0;
      i_valid  <= 1'b0;
      d_rdata  <= '0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      last_gnt <= last_gnt_n;
      owner    <= owner_n;
      cnt      <= cnt_n;
      m_req    <= m_req_n;
      m_we     <= m_we_n;
      m_addr   <= m_addr_n;
      m_wdata  <= m_wdata_n;
      i_rdata  <= i_rdata_n;
      i_valid  <= i_valid_n;
      d_rdata  <= d_rdata_n;
      d_valid  <= d_valid_n;
      err      <= err_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    last_gnt_n = last_gnt;
    owner_n    = owner;
    cnt_n      = cnt;
    grant_d    = 1'b0;
    m_req_n    = m_req;
    m_we_n     = m_we;
    m_addr_n   = m_addr;
    m_wdata_n  = m_wdata;
    i_rdata_n  = i_rdata;
    d_rdata_n  = d_rdata;
    i_valid_n  = 1'b0;
    d_valid_n  = 1'b0;
    err_n      = 1'b0;

    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          // Data wins only when alone or when instruction was served last.
          grant_d    = d_req && (!i_req || last_gnt == GNT_I);
          owner_n    = grant_d ? GNT_D : GNT_I;
          last_gnt_n = grant_d ? GNT_D : GNT_I;
          m_addr_n   = grant_d ? d_addr : i_addr;
          m_we_n     = grant_d && d_we;
          m_wdata_n  = d_wdata;
          m_req_n    = 1'b1;
          cnt_n      = '0;
          state_n    = BUSY;
        end
      end
      BUSY: begin
        if (m_ready) begin
          m_req_n = 1'b0;
          m_we_n  = 1'b0;
          if (owner == GNT_D) begin
            d_valid_n = 1'b1;
            if (!m_we) d_rdata_n = m_rdata;
          end else begin
            i_valid_n = 1'b1;
            i_rdata_n = m_rdata;
          end
          state_n = DONE;
        end else if (cnt == CNT_LAST) begin
          m_req_n = 1'b0;
          m_we_n  = 1'b0;
          err_n   = 1'b1;
          if (owner == GNT_D) begin
            d_valid_n = 1'b1;
            d_rdata_n = '0;
          end else begin
            i_valid_n = 1'b1;
            i_rdata_n = '0;
          end
          state_n = DONE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DONE: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed vector table plus hand-written sequences (timeout, async reset,
// randomised back-to-back traffic) for cpu_mem_arbiter.
module tb_cpu_mem_arbiter;

  logic        clk, reset;
  logic        i_req, i_valid, d_req, d_we, d_valid, err;
  logic        m_req, m_we, m_ready, busy;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int nvec = 0;
  int nfail = 0;

  cpu_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic ireq; logic [31:0] iaddr; logic dreq; logic dwe;
    logic [31:0] daddr; logic [31:0] dwdata; logic [31:0] mrdata; logic mready;
    logic e_mreq; logic e_mwe; logic [31:0] e_maddr; logic [31:0] e_mwdata;
    logic e_iv; logic [31:0] e_ird; logic e_dv; logic [31:0] e_drd;
    logic e_err; logic e_busy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [133:0] got_v, exp_v;

  // random-phase state
  int          issued, done_i, done_d, issued_i, issued_d, rem;
  logic        acc, own_d, acc_we, pend_iv, pend_dv, drop_i, drop_d;
  logic [31:0] mod_ird, mod_drd;
  int          n_mreq;
  logic        got;

  initial begin
    reset = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; m_rdata = 0; m_ready = 0;

    // rst ireq iaddr dreq dwe daddr dwdata mrdata mready | mreq mwe maddr mwdata iv ird dv drd err busy
    vq.push_back('{0,0,0,0,0,0,0,0,0,                                     0,0,0,0,0,0,0,0,0,0});
    vq.push_back('{1,1,'h10,0,0,0,0,0,0,                                  1,0,'h10,0,0,0,0,0,0,1});
    vq.push_back('{1,1,'h10,0,0,0,0,'h2002000A,1,                         0,0,'h10,0,1,'h2002000A,0,0,0,1});
    vq.push_back('{1,0,'h10,0,0,0,0,0,0,                                  0,0,'h10,0,0,'h2002000A,0,0,0,0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,                                     0,0,0,0,0,0,0,0,0,0});
    vq.push_back('{1,1,'h20,1,1,'h44,'h55,0,0,                            1,0,'h20,'h55,0,0,0,0,0,1});
    vq.push_back('{1,1,'h20,1,1,'h44,'h55,'h11111111,1,                   0,0,'h20,'h55,1,'h11111111,0,0,0,1});
    vq.push_back('{1,1,'h20,1,1,'h44,'h55,0,0,                            0,0,'h20,'h55,0,'h11111111,0,0,0,0});
    vq.push_back('{1,1,'h20,1,1,'h44,'h55,0,0,                            1,1,'h44,'h55,0,'h11111111,0,0,0,1});
    vq.push_back('{1,1,'h20,1,1,'h44,'h55,'h22222222,1,                   0,0,'h44,'h55,0,'h11111111,1,0,0,1});
    vq.push_back('{1,1,'h20,1,1,'h44,'h55,0,0,                            0,0,'h44,'h55,0,'h11111111,0,0,0,0});
    vq.push_back('{1,1,'h20,1,1,'h44,'h55,0,0,                            1,0,'h20,'h55,0,'h11111111,0,0,0,1});
    vq.push_back('{1,1,'h20,1,1,'h44,'h55,'h33333333,1,                   0,0,'h20,'h55,1,'h33333333,0,0,0,1});
    vq.push_back('{1,0,0,0,0,0,0,0,0,                                     0,0,'h20,'h55,0,'h33333333,0,0,0,0});
    vq.push_back('{1,0,0,1,0,'h40,0,0,0,                                  1,0,'h40,0,0,'h33333333,0,0,0,1});
    vq.push_back('{1,0,0,1,0,'h40,0,'hDEADBEEF,1,                         0,0,'h40,0,0,'h33333333,1,'hDEADBEEF,0,1});
    vq.push_back('{1,0,0,0,0,0,0,0,0,                                     0,0,'h40,0,0,'h33333333,0,'hDEADBEEF,0,0});
    vq.push_back('{1,0,0,1,1,'h40,'hCAFEF00D,0,0,                         1,1,'h40,'hCAFEF00D,0,'h33333333,0,'hDEADBEEF,0,1});
    vq.push_back('{1,0,0,1,1,'h40,'hCAFEF00D,0,0,                         1,1,'h40,'hCAFEF00D,0,'h33333333,0,'hDEADBEEF,0,1});
    vq.push_back('{1,0,'h77,1,1,'h99,'h0BADBEEF,0,0,                      1,1,'h40,'hCAFEF00D,0,'h33333333,0,'hDEADBEEF,0,1});
    vq.push_back('{1,0,0,1,1,'h40,'hCAFEF00D,0,0,                         1,1,'h40,'hCAFEF00D,0,'h33333333,0,'hDEADBEEF,0,1});
    vq.push_back('{1,0,0,1,1,'h40,'hCAFEF00D,'h12345678,1,                0,0,'h40,'hCAFEF00D,0,'h33333333,1,'hDEADBEEF,0,1});
    vq.push_back('{1,0,0,0,0,0,0,0,0,                                     0,0,'h40,'hCAFEF00D,0,'h33333333,0,'hDEADBEEF,0,0});

    for (int k = 0; k < vq.size(); k++) begin
      reset = vq[k].rst; i_req = vq[k].ireq; i_addr = vq[k].iaddr;
      d_req = vq[k].dreq; d_we = vq[k].dwe; d_addr = vq[k].daddr;
      d_wdata = vq[k].dwdata; m_rdata = vq[k].mrdata; m_ready = vq[k].mready;
      @(posedge clk); #1;
      got_v = {m_req, m_we, m_addr, m_wdata, i_valid, i_rdata, d_valid, d_rdata, err, busy};
      exp_v = {vq[k].e_mreq, vq[k].e_mwe, vq[k].e_maddr, vq[k].e_mwdata, vq[k].e_iv,
               vq[k].e_ird, vq[k].e_dv, vq[k].e_drd, vq[k].e_err, vq[k].e_busy};
      nvec++;
      if (got_v !== exp_v) begin
        nfail++;
        $display("FAIL vec%0d: got %h expected %h", k, got_v, exp_v);
      end
    end

    // Watchdog: data read with m_ready never asserted.
    i_req = 0; d_req = 1; d_we = 0; d_addr = 'h80; d_wdata = 0; m_ready = 0; m_rdata = 'hFFFFFFFF;
    n_mreq = 0; got = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (d_valid) begin got = 1; break; end
      if (m_req) n_mreq++;
    end
    chk("to_valid_seen", got, 1);
    chk("to_mreq_cycles", n_mreq, 15);
    chk("to_err", err, 1);
    chk("to_drdata", d_rdata, 0);
    chk("to_mreq_off", m_req, 0);
    chk("to_busy_done", busy, 1);
    chk("to_no_ivalid", i_valid, 0);
    d_req = 0; m_rdata = 0;
    @(posedge clk); #1;
    chk("to_busy_after", {busy, err, d_valid}, 0);

    // Asynchronous reset in the middle of a fetch.
    i_req = 1; i_addr = 'h30;
    @(posedge clk); #1;
    chk("rst_pre_mreq", m_req, 1);
    #3 reset = 0; d_req = 1; d_we = 0; d_addr = 'h50;
    #1;
    chk("rst_async_mreq", m_req, 0);
    chk("rst_async_busy", busy, 0);
    @(posedge clk); #1;
    chk("rst_no_ivalid", i_valid, 0);
    #2 reset = 1;
    @(posedge clk); #1;
    chk("rst_tie_mreq", m_req, 1);
    chk("rst_tie_maddr", m_addr, 'h30);
    chk("rst_tie_mwe", m_we, 0);
    m_ready = 1; m_rdata = 'hABCD1234;
    @(posedge clk); #1;
    chk("rst_ivalid", i_valid, 1);
    chk("rst_irdata", i_rdata, 'hABCD1234);
    chk("rst_dvalid_idle", d_valid, 0);
    i_req = 0; m_ready = 0; m_rdata = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_d_maddr", m_addr, 'h50);
    m_ready = 1; m_rdata = 'h5;
    @(posedge clk); #1;
    chk("rst_dvalid", d_valid, 1);
    chk("rst_drdata", d_rdata, 'h5);
    d_req = 0; m_ready = 0; m_rdata = 0;
    @(posedge clk); #1;

    // Random back-to-back traffic, wait states 0..5.
    issued = 0; issued_i = 0; issued_d = 0; done_i = 0; done_d = 0; rem = 0;
    acc = 0; own_d = 0; acc_we = 0; pend_iv = 0; pend_dv = 0;
    mod_ird = 'hABCD1234; mod_drd = 'h5;
    for (int cyc = 0; cyc < 4000 && (done_i + done_d) < 100; cyc++) begin
      @(posedge clk); #1;
      chk("rnd_ivalid", i_valid, pend_iv);
      chk("rnd_dvalid", d_valid, pend_dv);
      drop_i = 0; drop_d = 0;
      if (i_valid) begin
        chk("rnd_irdata", i_rdata, mod_ird);
        chk("rnd_overlap_i", {m_req, err}, 0);
        done_i++; i_req = 0; drop_i = 1;
      end
      if (d_valid) begin
        chk("rnd_drdata", d_rdata, mod_drd);
        chk("rnd_overlap_d", {m_req, err}, 0);
        done_d++; d_req = 0; drop_d = 1;
      end
      pend_iv = 0; pend_dv = 0;
      m_ready = 0;
      if (m_req) begin
        if (!acc) begin
          acc = 1;
          own_d = (m_addr[31:28] == 4'h2);
          acc_we = own_d && d_we;
          chk("rnd_owner_req", own_d ? d_req : i_req, 1);
          chk("rnd_maddr", m_addr, own_d ? d_addr : i_addr);
          chk("rnd_mwe", m_we, acc_we);
          if (acc_we) chk("rnd_mwdata", m_wdata, d_wdata);
          rem = $urandom_range(0, 5);
        end
        if (rem == 0) begin
          m_ready = 1; m_rdata = $urandom; acc = 0;
          if (own_d) begin
            pend_dv = 1;
            if (!acc_we) mod_drd = m_rdata;
          end else begin
            pend_iv = 1; mod_ird = m_rdata;
          end
        end else begin
          rem--;
        end
      end
      if (!i_req && !drop_i && issued < 100 && $urandom_range(0, 1) == 1) begin
        i_req = 1; i_addr = {4'h1, 28'($urandom)}; issued++; issued_i++;
      end
      if (!d_req && !drop_d && issued < 100 && $urandom_range(0, 1) == 1) begin
        d_req = 1; d_addr = {4'h2, 28'($urandom)}; d_we = 1'($urandom_range(0, 1));
        d_wdata = $urandom; issued++; issued_d++;
      end
    end
    chk("rnd_total_done", done_i + done_d, 100);
    chk("rnd_i_done", done_i, issued_i);
    chk("rnd_d_done", done_d, issued_d);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
